// File: rtl/enclave_pkg.sv
// Shared types for the SRAM port arbiter: owner encoding, pipeline stage
// control structs and default address/data widths.
package enclave_pkg;

   localparam int ADDR_W_DEF = 8;
   localparam int DATA_W_DEF = 32;

   typedef enum logic {
      OWN_HOST = 1'b0,
      OWN_ENG  = 1'b1
   } owner_e;

   // Stage control fields; S1 address/data are parameter-width and live beside it.
   typedef struct packed {
      logic   valid;
      owner_e owner;
      logic   we;
   } s1_t;

   typedef struct packed {
      logic   valid;
      owner_e owner;
   } s2_t;

endpackage

// File: rtl/sram_arb_starve_ctr.sv
// Saturating count of consecutive engine denials; raises force_eng once the
// engine has waited STARVE_MAX cycles so the next arbitration goes its way.
module sram_arb_starve_ctr #(
   parameter int STARVE_MAX = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic eng_req,
   input  logic eng_gnt,
   output logic force_eng
);

   localparam logic [3:0] LIMIT = 4'(STARVE_MAX);

   logic [3:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (!eng_req || eng_gnt) begin
         count <= '0;
      end else if (count != LIMIT) begin
         count <= count + 4'd1;
      end
   end

   assign force_eng = eng_req & (count == LIMIT);

endmodule

// File: rtl/sram_port_arbiter.sv
// Host/engine arbiter for a single-port 1-cycle SRAM with an in-order read
// return pipeline. Define ARB_STARVE_GUARD_EN to enable the engine starvation guard.
module sram_port_arbiter
   import enclave_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int STARVE_MAX = 4
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_ni,
   input  logic              host_req_i,
   input  logic              host_we_i,
   input  logic [ADDR_W-1:0] host_addr_i,
   input  logic [DATA_W-1:0] host_wdata_i,
   output logic              host_gnt_o,
   output logic              host_rvalid_o,
   output logic [DATA_W-1:0] host_rdata_o,
   input  logic              eng_req_i,
   input  logic              eng_we_i,
   input  logic [ADDR_W-1:0] eng_addr_i,
   input  logic [DATA_W-1:0] eng_wdata_i,
   output logic              eng_gnt_o,
   output logic              eng_rvalid_o,
   output logic [DATA_W-1:0] eng_rdata_o,
   output logic              sram_csb_o,
   output logic              sram_web_o,
   output logic [ADDR_W-1:0] sram_addr_o,
   output logic [DATA_W-1:0] sram_din_o,
   input  logic [DATA_W-1:0] sram_dout_i,
   output logic              busy_o
);

   logic              force_eng;
   logic              host_gnt;
   logic              eng_gnt;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

   s1_t               s1;
   logic [ADDR_W-1:0] s1_addr;
   logic [DATA_W-1:0] s1_wdata;
   s2_t               s2;

   logic              host_rvalid;
   logic [DATA_W-1:0] host_rdata;
   logic              eng_rvalid;
   logic [DATA_W-1:0] eng_rdata;

`ifdef ARB_STARVE_GUARD_EN
   sram_arb_starve_ctr #(
      .STARVE_MAX (STARVE_MAX)
   ) u_starve_ctr (
      .clk       (wb_clk_i),
      .rst_n     (wb_rst_ni),
      .eng_req   (eng_req_i),
      .eng_gnt   (eng_gnt),
      .force_eng (force_eng)
   );
`else
   logic [31:0] unused_starve_max;
   assign unused_starve_max = 32'(STARVE_MAX);
   assign force_eng         = 1'b0;
`endif

   // Grants are held low during reset so nothing is accepted while S1 is cleared.
   always_comb begin
      host_gnt  = wb_rst_ni & host_req_i & ~force_eng;
      eng_gnt   = wb_rst_ni & eng_req_i & (~host_req_i | force_eng);
      sel_we    = host_we_i;
      sel_addr  = host_addr_i;
      sel_wdata = host_wdata_i;
      if (eng_gnt) begin
         sel_we    = eng_we_i;
         sel_addr  = eng_addr_i;
         sel_wdata = eng_wdata_i;
      end
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         s1          <= '0;
         s1_addr     <= '0;
         s1_wdata    <= '0;
         s2          <= '0;
         host_rvalid <= 1'b0;
         host_rdata  <= '0;
         eng_rvalid  <= 1'b0;
         eng_rdata   <= '0;
      end else begin
         s1.valid <= host_gnt | eng_gnt;
         s1.owner <= eng_gnt ? OWN_ENG : OWN_HOST;
         s1.we    <= sel_we;
         // Address/data only move on a grant so an idle SRAM sees no toggling.
         if (host_gnt || eng_gnt) begin
            s1_addr  <= sel_addr;
            s1_wdata <= sel_wdata;
         end
         s2.valid    <= s1.valid & ~s1.we;
         s2.owner    <= s1.owner;
         host_rvalid <= s2.valid & (s2.owner == OWN_HOST);
         eng_rvalid  <= s2.valid & (s2.owner == OWN_ENG);
         if (s2.valid && s2.owner == OWN_HOST) begin
            host_rdata <= sram_dout_i;
         end
         if (s2.valid && s2.owner == OWN_ENG) begin
            eng_rdata <= sram_dout_i;
         end
      end
   end

   assign host_gnt_o    = host_gnt;
   assign eng_gnt_o     = eng_gnt;
   assign host_rvalid_o = host_rvalid;
   assign host_rdata_o  = host_rdata;
   assign eng_rvalid_o  = eng_rvalid;
   assign eng_rdata_o   = eng_rdata;
   assign sram_csb_o    = ~s1.valid;
   assign sram_web_o    = ~(s1.valid & s1.we);
   assign sram_addr_o   = s1_addr;
   assign sram_din_o    = s1_wdata;
   assign busy_o        = s1.valid | s2.valid;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed self-checking bench for sram_port_arbiter with a behavioural
// 1-cycle SRAM; starvation expectations follow ARB_STARVE_GUARD_EN.
module tb_sram_port_arbiter;

   logic        clk;
   logic        rst_n;
   logic        host_req;
   logic        host_we;
   logic [7:0]  host_addr;
   logic [31:0] host_wdata;
   logic        host_gnt;
   logic        host_rvalid;
   logic [31:0] host_rdata;
   logic        eng_req;
   logic        eng_we;
   logic [7:0]  eng_addr;
   logic [31:0] eng_wdata;
   logic        eng_gnt;
   logic        eng_rvalid;
   logic [31:0] eng_rdata;
   logic        sram_csb;
   logic        sram_web;
   logic [7:0]  sram_addr;
   logic [31:0] sram_din;
   logic [31:0] sram_dout;
   logic        busy;

   int checks   = 0;
   int failures = 0;

   logic [31:0] mem [256];

   sram_port_arbiter dut (
      .wb_clk_i      (clk),
      .wb_rst_ni     (rst_n),
      .host_req_i    (host_req),
      .host_we_i     (host_we),
      .host_addr_i   (host_addr),
      .host_wdata_i  (host_wdata),
      .host_gnt_o    (host_gnt),
      .host_rvalid_o (host_rvalid),
      .host_rdata_o  (host_rdata),
      .eng_req_i     (eng_req),
      .eng_we_i      (eng_we),
      .eng_addr_i    (eng_addr),
      .eng_wdata_i   (eng_wdata),
      .eng_gnt_o     (eng_gnt),
      .eng_rvalid_o  (eng_rvalid),
      .eng_rdata_o   (eng_rdata),
      .sram_csb_o    (sram_csb),
      .sram_web_o    (sram_web),
      .sram_addr_o   (sram_addr),
      .sram_din_o    (sram_din),
      .sram_dout_i   (sram_dout),
      .busy_o        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory preloaded with 0xA50000nn so unwritten reads are predictable.
   initial begin
      for (int i = 0; i < 256; i++) begin
         mem[i] <= 32'hA500_0000 | 32'(i);
      end
   end

   always @(posedge clk) begin
      if (!sram_csb) begin
         if (!sram_web) begin
            mem[sram_addr] <= sram_din;
         end else begin
            sram_dout <= mem[sram_addr];
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic rst, input logic h_req, input logic h_we,
                                input logic [7:0] h_addr, input logic [31:0] h_wdata,
                                input logic e_req, input logic e_we,
                                input logic [7:0] e_addr, input logic [31:0] e_wdata);
      @(negedge clk);
      rst_n      = rst;
      host_req   = h_req;
      host_we    = h_we;
      host_addr  = h_addr;
      host_wdata = h_wdata;
      eng_req    = e_req;
      eng_we     = e_we;
      eng_addr   = e_addr;
      eng_wdata  = e_wdata;
      #1;
   endtask

   task automatic idleCycle();
      applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic        guard;
      logic [7:0]  h_idx;
      rst_n = 1'b0; host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
      eng_req = 1'b0; eng_we = 1'b0; eng_addr = '0; eng_wdata = '0;
`ifdef ARB_STARVE_GUARD_EN
      guard = 1'b1;
`else
      guard = 1'b0;
`endif

      // Reset with a host request pending
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h12, 32'h0, 1'b1, 1'b0, 8'h00, 32'h0);
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h12, 32'h0, 1'b1, 1'b0, 8'h00, 32'h0);
      checkOutput("rst_host_gnt", host_gnt, 0);
      checkOutput("rst_eng_gnt", eng_gnt, 0);
      checkOutput("rst_csb", sram_csb, 1);
      checkOutput("rst_web", sram_web, 1);
      checkOutput("rst_addr", sram_addr, 0);
      checkOutput("rst_din", sram_din, 0);
      checkOutput("rst_rvalid", {host_rvalid, eng_rvalid}, 0);
      checkOutput("rst_rdata", host_rdata | eng_rdata, 0);
      checkOutput("rst_busy", busy, 0);
      idleCycle();
      checkOutput("idle_csb", sram_csb, 1);

      // Host write 0x12 then read it back
      applyStimulus(1'b1, 1'b1, 1'b1, 8'h12, 32'hDEAD_BEEF, 1'b0, 1'b0, 8'h00, 32'h0);
      checkOutput("wr_host_gnt", host_gnt, 1);
      checkOutput("wr_eng_gnt", eng_gnt, 0);
      idleCycle();
      checkOutput("wr_csb", sram_csb, 0);
      checkOutput("wr_web", sram_web, 0);
      checkOutput("wr_addr", sram_addr, 32'h12);
      checkOutput("wr_din", sram_din, 32'hDEAD_BEEF);
      checkOutput("wr_busy", busy, 1);
      applyStimulus(1'b1, 1'b1, 1'b0, 8'h12, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0);
      checkOutput("rd_host_gnt", host_gnt, 1);
      checkOutput("rd_prev_csb", sram_csb, 1);
      idleCycle();
      checkOutput("rd_csb", sram_csb, 0);
      checkOutput("rd_web", sram_web, 1);
      checkOutput("rd_addr", sram_addr, 32'h12);
      idleCycle();
      checkOutput("rd_t2_rvalid", host_rvalid, 0);
      checkOutput("rd_t2_busy", busy, 1);
      idleCycle();
      checkOutput("rd_t3_rvalid", host_rvalid, 1);
      checkOutput("rd_t3_rdata", host_rdata, 32'hDEAD_BEEF);
      checkOutput("rd_t3_eng_rvalid", eng_rvalid, 0);
      checkOutput("rd_t3_busy", busy, 0);
      idleCycle();
      checkOutput("rd_t4_rvalid", host_rvalid, 0);
      checkOutput("rd_t4_rdata_hold", host_rdata, 32'hDEAD_BEEF);

      // Simultaneous reads: host first, engine next cycle
      applyStimulus(1'b1, 1'b1, 1'b0, 8'h01, 32'h0, 1'b1, 1'b0, 8'h02, 32'h0);
      checkOutput("sim_host_gnt", host_gnt, 1);
      checkOutput("sim_eng_gnt0", eng_gnt, 0);
      applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 8'h02, 32'h0);
      checkOutput("sim_eng_gnt1", eng_gnt, 1);
      checkOutput("sim_host_gnt1", host_gnt, 0);
      idleCycle();
      idleCycle();
      checkOutput("sim_host_rvalid", host_rvalid, 1);
      checkOutput("sim_host_rdata", host_rdata, 32'hA500_0001);
      checkOutput("sim_eng_rvalid0", eng_rvalid, 0);
      idleCycle();
      checkOutput("sim_eng_rvalid", eng_rvalid, 1);
      checkOutput("sim_eng_rdata", eng_rdata, 32'hA500_0002);
      checkOutput("sim_host_rvalid1", host_rvalid, 0);

      // Host write followed immediately by engine read of the same word
      applyStimulus(1'b1, 1'b1, 1'b1, 8'h20, 32'h1234_5678, 1'b0, 1'b0, 8'h00, 32'h0);
      applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 8'h20, 32'h0);
      checkOutput("raw_eng_gnt", eng_gnt, 1);
      idleCycle();
      idleCycle();
      idleCycle();
      checkOutput("raw_eng_rvalid", eng_rvalid, 1);
      checkOutput("raw_eng_rdata", eng_rdata, 32'h1234_5678);

      // Host saturates the port while the engine waits
      h_idx = 8'h30;
      for (int i = 0; i < 6; i++) begin
         logic e_req_now;
         e_req_now = guard ? (i <= 4) : 1'b1;
         applyStimulus(1'b1, 1'b1, 1'b0, h_idx, 32'h0, e_req_now, 1'b0, 8'h40, 32'h0);
         checkOutput($sformatf("starve_eng_gnt%0d", i), eng_gnt, (guard && i == 4) ? 1 : 0);
         checkOutput($sformatf("starve_host_gnt%0d", i), host_gnt, (guard && i == 4) ? 0 : 1);
         if (host_gnt) h_idx = h_idx + 8'd1;
      end
      applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 32'h0, ~guard, 1'b0, 8'h40, 32'h0);
      checkOutput("starve_release_eng_gnt", eng_gnt, guard ? 0 : 1);
      for (int i = 0; i < 5; i++) idleCycle();
      checkOutput("starve_drain_busy", busy, 0);

      // Reset one cycle after a read grant drops the read
      applyStimulus(1'b1, 1'b1, 1'b0, 8'h05, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0);
      checkOutput("mid_host_gnt", host_gnt, 1);
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0);
      checkOutput("mid_csb", sram_csb, 1);
      checkOutput("mid_busy", busy, 0);
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0);
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0);
      checkOutput("mid_rvalid", host_rvalid, 0);
      checkOutput("mid_rdata", host_rdata, 0);
      idleCycle();
      checkOutput("mid_post_rvalid", host_rvalid, 0);
      applyStimulus(1'b1, 1'b1, 1'b0, 8'h05, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0);
      checkOutput("post_host_gnt", host_gnt, 1);
      idleCycle();
      idleCycle();
      idleCycle();
      checkOutput("post_rvalid", host_rvalid, 1);
      checkOutput("post_rdata", host_rdata, 32'hA500_0005);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
